// File: rtl/am_envelope_detector.sv
// AM envelope detector: sequential CORDIC magnitude, shift-add gain
// correction and a leaky-average DC blocker on decimated I/Q pairs.
module am_envelope_detector #(
    parameter int BITS     = 16,
    parameter int ITER     = 12,
    parameter int DC_SHIFT = 10
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic signed [BITS-1:0] i_in,
    input  logic signed [BITS-1:0] q_in,
    input  logic                   in_tick,
    output logic signed [BITS-1:0] env_out,
    output logic                   out_tick,
    output logic                   busy,
    output logic                   overrun
);

    localparam int W  = BITS + 2;
    localparam int AW = W + DC_SHIFT;
    localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [W:0] SMAX = (W+1)'(2**(BITS-1) - 1);
    localparam logic signed [W:0] SMIN = (W+1)'(-(2**(BITS-1)));

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        SCALE,
        DCBLK
    } state_t;

    state_t state, state_n;

    logic [KW-1:0]          k, k_n;
    logic                   phase, phase_n;
    logic signed [W-1:0]    x, x_n, y, y_n;
    logic signed [W-1:0]    pa, pa_n, pb, pb_n;
    logic signed [W-1:0]    mag, mag_n;
    logic signed [AW-1:0]   acc, acc_n;
    logic signed [BITS-1:0] env_n;
    logic                   out_tick_n;
    logic                   overrun_n;

    logic signed [W-1:0]    ie, qe, xs, ys, dc;
    logic signed [W:0]      diff;

    assign ie   = {{2{i_in[BITS-1]}}, i_in};
    assign qe   = {{2{q_in[BITS-1]}}, q_in};
    assign xs   = x >>> k;
    assign ys   = y >>> k;
    assign dc   = acc[AW-1:DC_SHIFT];
    assign diff = {mag[W-1], mag} - {dc[W-1], dc};
    assign busy = (state != IDLE);

    always_comb begin
        state_n    = state;
        k_n        = k;
        phase_n    = phase;
        x_n        = x;
        y_n        = y;
        pa_n       = pa;
        pb_n       = pb;
        mag_n      = mag;
        acc_n      = acc;
        env_n      = env_out;
        out_tick_n = 1'b0;
        overrun_n  = overrun;
        if (in_tick && state != IDLE) begin
            overrun_n = 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (in_tick) begin
                    state_n = ROTATE;
                    k_n     = '0;
                    phase_n = 1'b0;
                    // fold the left half-plane so the CORDIC range suffices
                    if (i_in[BITS-1]) begin
                        x_n = -ie;
                        y_n = -qe;
                    end else begin
                        x_n = ie;
                        y_n = qe;
                    end
                end
            end
            ROTATE: begin
                if (!y[W-1]) begin
                    x_n = x + ys;
                    y_n = y - xs;
                end else begin
                    x_n = x - ys;
                    y_n = y + xs;
                end
                if (k == KW'(ITER - 1)) begin
                    state_n = SCALE;
                    k_n     = '0;
                end else begin
                    k_n = k + KW'(1);
                end
            end
            SCALE: begin
                // gain correction split over two cycles: partials, then difference
                if (!phase) begin
                    pa_n    = (x >>> 1) + (x >>> 3);
                    pb_n    = (x >>> 6) + (x >>> 9);
                    phase_n = 1'b1;
                end else begin
                    mag_n   = pa - pb;
                    phase_n = 1'b0;
                    state_n = DCBLK;
                end
            end
            DCBLK: begin
                if (diff > SMAX) begin
                    env_n = SMAX[BITS-1:0];
                end else if (diff < SMIN) begin
                    env_n = SMIN[BITS-1:0];
                end else begin
                    env_n = diff[BITS-1:0];
                end
                acc_n      = acc + AW'(diff);
                out_tick_n = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            k        <= '0;
            phase    <= 1'b0;
            x        <= '0;
            y        <= '0;
            pa       <= '0;
            pb       <= '0;
            mag      <= '0;
            acc      <= '0;
            env_out  <= '0;
            out_tick <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            phase    <= phase_n;
            x        <= x_n;
            y        <= y_n;
            pa       <= pa_n;
            pb       <= pb_n;
            mag      <= mag_n;
            acc      <= acc_n;
            env_out  <= env_n;
            out_tick <= out_tick_n;
            overrun  <= overrun_n;
        end
    end

endmodule

// File: tb/tb_am_envelope_detector.sv
// Directed testbench for am_envelope_detector: latency, magnitude,
// saturation, DC blocking, overrun and mid-sample reset.
module tb_am_envelope_detector;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic in_tick = 1'b0;
    logic tick4 = 1'b0;
    logic signed [15:0] i_in = '0;
    logic signed [15:0] q_in = '0;
    logic signed [15:0] env_out, env4;
    logic out_tick, busy, overrun;
    logic ot4, busy4, ovr4;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    am_envelope_detector u_dut (
        .CLK(CLK), .RST(RST), .i_in(i_in), .q_in(q_in),
        .in_tick(in_tick), .env_out(env_out), .out_tick(out_tick),
        .busy(busy), .overrun(overrun)
    );

    am_envelope_detector #(.DC_SHIFT(4)) u_dc4 (
        .CLK(CLK), .RST(RST), .i_in(i_in), .q_in(q_in),
        .in_tick(tick4), .env_out(env4), .out_tick(ot4),
        .busy(busy4), .overrun(ovr4)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        in_tick = 1'b0;
        tick4 = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic send(input int i, input int q);
        @(negedge CLK);
        i_in = 16'(i);
        q_in = 16'(q);
        in_tick = 1'b1;
        @(negedge CLK);
        in_tick = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (!out_tick && lat < 40) begin
            if (busy) bcnt++;
            @(negedge CLK);
            lat++;
        end
        checks++;
        if (lat >= 40) begin
            failures++;
            $display("FAIL out_tick_timeout got=no out_tick want=out_tick");
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (env_out !== 16'sd0) begin
            failures++;
            $display("FAIL reset_env got=%0d want=0", env_out);
        end
        checks++;
        if (out_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_tick got=%b want=0", out_tick);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_overrun got=%b want=0", overrun);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt, d;
        do_reset();
        send(16384, 0);
        wait_out(lat, bcnt);
        checks++;
        if (lat != 15) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=15", lat);
        end
        checks++;
        if (bcnt != 15) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d want=15", bcnt);
        end
        d = int'(env_out) - 16384;
        checks++;
        if (d > 35 || d < -35) begin
            failures++;
            $display("FAIL basic_env got=%0d want=16384+-35", env_out);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL basic_overrun got=%b want=0", overrun);
        end
        @(negedge CLK);
        checks++;
        if (out_tick !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_one_tick got=%b/%b want=0/0", out_tick, busy);
        end
        repeat (5) @(negedge CLK);
        d = int'(env_out) - 16384;
        checks++;
        if (d > 35 || d < -35) begin
            failures++;
            $display("FAIL basic_hold got=%0d want=16384+-35", env_out);
        end
    endtask

    task automatic test_quadrants();
        int lat, bcnt, d;
        do_reset();
        send(-12000, -9000);
        wait_out(lat, bcnt);
        d = int'(env_out) - 15000;
        checks++;
        if (d > 32 || d < -32) begin
            failures++;
            $display("FAIL neg_iq_env got=%0d want=15000+-32", env_out);
        end
        do_reset();
        send(0, -20000);
        wait_out(lat, bcnt);
        d = int'(env_out) - 20000;
        checks++;
        if (d > 42 || d < -42) begin
            failures++;
            $display("FAIL neg_q_env got=%0d want=20000+-42", env_out);
        end
    endtask

    task automatic test_saturation();
        int lat, bcnt;
        do_reset();
        send(-32768, -32768);
        wait_out(lat, bcnt);
        checks++;
        if (env_out !== 16'sd32767) begin
            failures++;
            $display("FAIL sat_env got=%0d want=32767", env_out);
        end
    endtask

    task automatic test_dc_decay();
        int v, prev, got, d;
        do_reset();
        prev = 0;
        for (int s = 0; s < 300; s++) begin
            @(negedge CLK);
            i_in = 16'sd10000;
            q_in = 16'sd10000;
            tick4 = 1'b1;
            got = 0;
            v = 0;
            for (int c = 0; c < 19; c++) begin
                @(negedge CLK);
                tick4 = 1'b0;
                if (ot4) begin
                    got++;
                    v = int'(env4);
                end
            end
            checks++;
            if (got != 1) begin
                failures++;
                $display("FAIL dc_tick_count s=%0d got=%0d want=1", s, got);
            end
            if (s == 0) begin
                d = v - 14142;
                checks++;
                if (d > 30 || d < -30) begin
                    failures++;
                    $display("FAIL dc_first got=%0d want=14142+-30", v);
                end
            end else begin
                checks++;
                if (v > prev) begin
                    failures++;
                    $display("FAIL dc_monotonic s=%0d got=%0d want<=%0d", s, v, prev);
                end
            end
            if (s > 250) begin
                checks++;
                if (v > 2 || v < -2) begin
                    failures++;
                    $display("FAIL dc_settled s=%0d got=%0d want=|x|<=2", s, v);
                end
            end
            prev = v;
        end
    endtask

    task automatic test_overrun();
        int n, ots, d;
        do_reset();
        send(16384, 0);
        n = 0;
        ots = 0;
        repeat (4) begin
            @(negedge CLK);
            n++;
            if (out_tick) ots++;
        end
        i_in = 16'sd0;
        q_in = -16'sd20000;
        in_tick = 1'b1;
        @(negedge CLK);
        n++;
        in_tick = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_flag got=%b want=1", overrun);
        end
        while (!out_tick && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (out_tick) ots++;
        checks++;
        if (n != 15) begin
            failures++;
            $display("FAIL ovr_latency got=%0d want=15", n);
        end
        d = int'(env_out) - 16384;
        checks++;
        if (d > 35 || d < -35) begin
            failures++;
            $display("FAIL ovr_first_sample got=%0d want=16384+-35", env_out);
        end
        i_in = -16'sd12000;
        q_in = -16'sd9000;
        in_tick = 1'b1;
        @(negedge CLK);
        in_tick = 1'b0;
        if (out_tick) ots++;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ovr_accept_third got=%b want=1", busy);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_sticky got=%b want=1", overrun);
        end
        checks++;
        if (ots != 1) begin
            failures++;
            $display("FAIL ovr_tick_count got=%0d want=1", ots);
        end
    endtask

    task automatic test_reset_mid();
        int ots, lat, bcnt, d;
        repeat (6) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (busy !== 1'b0 || env_out !== 16'sd0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=busy%b env%0d ovr%b want=busy0 env0 ovr0",
                     busy, env_out, overrun);
        end
        ots = 0;
        repeat (25) begin
            @(negedge CLK);
            if (out_tick) ots++;
        end
        checks++;
        if (ots != 0) begin
            failures++;
            $display("FAIL mid_no_tick got=%0d want=0", ots);
        end
        send(16384, 0);
        wait_out(lat, bcnt);
        d = int'(env_out) - 16384;
        checks++;
        if (d > 35 || d < -35) begin
            failures++;
            $display("FAIL mid_after_env got=%0d want=16384+-35", env_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_quadrants();
        test_saturation();
        test_dc_decay();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/am_envelope_detector.md
Name: am_envelope_detector

Overview:
- Downstream consumer of the I and Q CIC decimator outputs in the 1-bit AM receiver.
- On each decimated I/Q sample pair, computes the magnitude |I + jQ| with a sequential CORDIC in vectoring mode, corrects the CORDIC gain with a shift-add scale, and removes the carrier DC with a first-order leaky-average DC blocker.
- Emits one signed audio sample per input pair, with a one-cycle out_tick, to the audio/PWM stage.

Parameters:
- BITS, 16, width of i_in, q_in and env_out.
- ITER, 12, number of CORDIC iterations (1..BITS).
- DC_SHIFT, 10, DC-blocker pole: dc tracks the magnitude with coefficient 2^-DC_SHIFT.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous reset, active-high.
- i_in  input  BITS  signed in-phase sample from the I CIC.
- q_in  input  BITS  signed quadrature sample from the Q CIC.
- in_tick  input  1  one-cycle strobe: i_in and q_in are valid this cycle.
- env_out  output  BITS  signed DC-removed envelope sample (registered).
- out_tick  output  1  high for exactly one cycle when env_out updates.
- busy  output  1  high while a sample is in process (any state other than IDLE).
- overrun  output  1  sticky flag: an in_tick arrived while busy; cleared only by RST.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values:
  - env_out = 0, out_tick = 0, busy = 0, overrun = 0.
  - state = IDLE, iteration counter = 0, all datapath registers = 0, dc_acc = 0.
  - RST asserted in any state (mid-rotation included) aborts the sample; no out_tick is produced for it.
- Internal widths:
  - CORDIC x/y are signed W = BITS+2 bits.
  - dc_acc is signed BITS+2+DC_SHIFT bits.
- FSM states: IDLE -> ROTATE -> SCALE -> DCBLK -> IDLE.
- IDLE:
  - When in_tick = 1, capture the sample and go to ROTATE, with k = 0.
  - Capture is sign-extended to W: if i_in < 0 then x = -i_in, y = -q_in; otherwise x = i_in, y = q_in.
- ROTATE, one iteration per cycle, k = 0..ITER-1:
  - if y >= 0: x <= x + (y >>> k), y <= y - (x >>> k).
  - else: x <= x - (y >>> k), y <= y + (x >>> k).
  - Both updates use the old x and y values.
  - After the iteration with k = ITER-1, go to SCALE.
- SCALE:
  - mag = (x>>>1) + (x>>>3) - (x>>>6) - (x>>>9), which approximates x * 0.6074 (CORDIC gain correction).
  - Register mag in W bits; it is always >= 0.
  - Go to DCBLK.
- DCBLK:
  - dc = dc_acc >>> DC_SHIFT (uses the old dc_acc).
  - diff = mag - dc.
  - env_out <= diff saturated to [-2^(BITS-1), 2^(BITS-1)-1].
  - dc_acc <= dc_acc + mag - dc.
  - out_tick <= 1 on this cycle's edge; go to IDLE.
- out_tick is high only in the cycle after DCBLK and low in all other cycles.
- Latency:
  - in_tick sampled at edge 0 gives out_tick high and env_out valid after edge ITER+3.
  - With default ITER = 12 that is 15 cycles.
- Throughput: one sample per ITER+3 cycles. A new in_tick is accepted in the same cycle out_tick is high (state is IDLE then).
- in_tick while busy = 1: the sample is dropped, overrun <= 1, and the in-flight computation is unaffected.
- Simultaneous RST and in_tick: RST wins; the sample is not captured.
- Numeric checks:
  - Magnitude error is at most 0.2% of the true magnitude + 2 LSB for ITER = 12.
  - No internal overflow for any input, including -2^(BITS-1) on both inputs.
- env_out holds its value between out_ticks.

Test Plan:
- Reset, then i_in = 16384, q_in = 0, in_tick one cycle:
  - busy is high for 15 cycles.
  - out_tick rises exactly 15 cycles after in_tick.
  - env_out = 16384 ± 35 (dc = 0 on the first sample).
  - overrun = 0.
- After reset, i_in = -12000, q_in = -9000:
  - env_out = 15000 ± 32.
  - Repeat with i_in = 0, q_in = -20000: env_out = 20000 ± 42.
- DC_SHIFT = 4, constant i_in = 10000, q_in = 10000 sent on every 20th cycle for 300 samples:
  - first env_out ≈ 14142 ± 30.
  - the sequence decays monotonically.
  - |env_out| <= 2 after sample 250.
- i_in = -32768, q_in = -32768 after reset:
  - the magnitude is about 46341, so env_out = 32767 (positive saturation).
  - No wrap to negative values.
- Overrun: issue in_tick, then a second in_tick 5 cycles later with different data:
  - overrun = 1 and stays 1.
  - Exactly one out_tick, whose value corresponds to the first sample.
  - A third in_tick issued in the out_tick cycle is accepted (busy is high on the next cycle).
- Reset mid-operation: assert RST for one cycle at iteration k = 6:
  - the next cycle shows busy = 0, env_out = 0, overrun = 0.
  - No out_tick for the aborted sample.
  - A following sample i_in = 16384, q_in = 0 gives env_out = 16384 ± 35, confirming dc_acc was cleared.
